// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg
//   Shared definitions for the sequential floating-point units working on the
//   {sign, exp[EXP-1:0], mant[MANT-1:0]} format.
//
//   Contents:
//     EXP_DEF / MANT_DEF / BIAS_DEF  default format parameters (binary32)
//     MAXW                           widest operand word the helpers accept
//     state_t                        divider control states
//     fp_sign / fp_exp / fp_mant     field extraction from a zero-extended word
//     fp_is_zero                     zero test (exponent field == 0)
//
//   The helpers take the format widths as arguments so that one package serves
//   every parameterisation; callers zero-extend the operand to MAXW bits and
//   size-cast the result back to the field width.
// -----------------------------------------------------------------------------
package fp_pkg;

  localparam int EXP_DEF  = 8;
  localparam int MANT_DEF = 23;
  localparam int BIAS_DEF = 127;
  localparam int MAXW     = 64;

  typedef enum logic [2:0] {
    IDLE,
    NORM,
    DIV,
    ROUND,
    SPECIAL
  } state_t;

  function automatic logic fp_sign(input logic [MAXW-1:0] w,
                                   input int exp_w, input int mant_w);
    return |((w >> (exp_w + mant_w)) & MAXW'(1));
  endfunction

  function automatic logic [MAXW-1:0] fp_exp(input logic [MAXW-1:0] w,
                                             input int exp_w, input int mant_w);
    return (w >> mant_w) & ((MAXW'(1) << exp_w) - MAXW'(1));
  endfunction

  function automatic logic [MAXW-1:0] fp_mant(input logic [MAXW-1:0] w,
                                              input int exp_w, input int mant_w);
    // exp_w is accepted only for a uniform call signature
    return (w & ((MAXW'(1) << mant_w) - MAXW'(1))) | (MAXW'(exp_w) & MAXW'(0));
  endfunction

  // Denormals are flushed: the mantissa is ignored when the exponent is zero.
  function automatic logic fp_is_zero(input logic [MAXW-1:0] w,
                                      input int exp_w, input int mant_w);
    return fp_exp(w, exp_w, mant_w) == '0;
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// -----------------------------------------------------------------------------
// fp_round_rne
//   Combinational round-to-nearest-even on a normalised fraction.
//
//   Ports:
//     frac_i   [MANT-1:0]  fraction before rounding (hidden bit excluded)
//     guard_i              first bit below the fraction lsb
//     sticky_i             OR of every bit below the guard bit
//     exp_i    [EXP-1:0]   biased exponent before rounding
//     frac_o   [MANT-1:0]  rounded fraction
//     exp_o    [EXP-1:0]   exponent, incremented (mod 2^EXP) on fraction carry
// -----------------------------------------------------------------------------
module fp_round_rne
  import fp_pkg::*;
#(
  parameter int EXP  = EXP_DEF,
  parameter int MANT = MANT_DEF
) (
  input  logic [MANT-1:0] frac_i,
  input  logic            guard_i,
  input  logic            sticky_i,
  input  logic [EXP-1:0]  exp_i,
  output logic [MANT-1:0] frac_o,
  output logic [EXP-1:0]  exp_o
);

  // Ties (guard set, nothing below) round toward the even fraction.
  function automatic logic rne_up(input logic lsb, input logic guard,
                                  input logic sticky);
    return guard & (sticky | lsb);
  endfunction

  logic [MANT:0] sum;

  always_comb begin
    sum    = {1'b0, frac_i} + {{MANT{1'b0}}, rne_up(frac_i[0], guard_i, sticky_i)};
    frac_o = sum[MANT-1:0];
    // A carry out of an all-ones fraction leaves 1.0 x 2^(e+1): fraction wraps to 0.
    exp_o  = exp_i + {{(EXP-1){1'b0}}, sum[MANT]};
  end

endmodule

// File: rtl/fdiv_seq.sv
// -----------------------------------------------------------------------------
// fdiv_seq
//   Sequential floating-point divider c = a / b using restoring mantissa
//   division, one quotient bit per clock, with round-to-nearest-even.
//   No denormal, NaN or infinity inputs; exponent arithmetic wraps mod 2^EXP.
//
//   Ports:
//     clk_i    clock, rising edge
//     rst_ni   asynchronous active-low reset
//     start_i  request, sampled only while idle
//     a_i      dividend {sign, exp, mant}
//     b_i      divisor  {sign, exp, mant}
//     busy_o   operation in progress
//     done_o   one-cycle pulse, c_o/dbz_o valid from this cycle on
//     c_o      quotient, held until the next done_o
//     dbz_o    divide-by-zero flag for the result on c_o
//
//   Timing (edge 0 = capture): a zero operand finishes on edge 1; otherwise
//   NORM on edge 1, MANT+2 DIV iterations on edges 2..MANT+3, ROUND on edge
//   MANT+4.
// -----------------------------------------------------------------------------
module fdiv_seq
  import fp_pkg::*;
#(
  parameter int EXP  = EXP_DEF,
  parameter int MANT = MANT_DEF,
  parameter int BIAS = BIAS_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [EXP+MANT:0] a_i,
  input  logic [EXP+MANT:0] b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [EXP+MANT:0] c_o,
  output logic              dbz_o
);

  localparam int W  = 1 + EXP + MANT;
  localparam int RW = MANT + 3;            // remainder holds up to 2*mb - 1
  localparam int CW = $clog2(MANT + 3);

  localparam logic [EXP-1:0] BIAS_E  = EXP'(BIAS);
  localparam logic [CW-1:0]  LAST_IT = CW'(MANT + 1);

  // Control and output registers
  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic           busy_q;
  logic           done_q;
  logic           dbz_q;
  logic [W-1:0]   c_q;

  // Datapath registers
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [MANT:0]  mb_q;
  logic [RW-1:0]  r_q;
  logic [MANT:0]  quo_q;                   // fraction + guard; hidden bit shifts out
  logic [EXP-1:0] e_q;

  // Operand decode
  logic          sign_c;
  logic          zero_b;
  logic          zero_in;
  logic [MANT:0] ma_d;
  logic [MANT:0] mb_d;
  logic          adj_d;
  logic [EXP-1:0] e_d;
  logic [RW-1:0] r_d;

  always_comb begin
    sign_c  = fp_sign(MAXW'(a_q), EXP, MANT) ^ fp_sign(MAXW'(b_q), EXP, MANT);
    zero_b  = fp_is_zero(MAXW'(b_q), EXP, MANT);
    zero_in = fp_is_zero(MAXW'(a_i), EXP, MANT) | fp_is_zero(MAXW'(b_i), EXP, MANT);

    ma_d  = {1'b1, MANT'(fp_mant(MAXW'(a_q), EXP, MANT))};
    mb_d  = {1'b1, MANT'(fp_mant(MAXW'(b_q), EXP, MANT))};
    // Pre-shifting a smaller dividend keeps the first quotient bit at 1.
    adj_d = ma_d < mb_d;
    e_d   = EXP'(fp_exp(MAXW'(a_q), EXP, MANT)) - EXP'(fp_exp(MAXW'(b_q), EXP, MANT))
            + BIAS_E - EXP'(adj_d);
    r_d   = adj_d ? {1'b0, ma_d, 1'b0} : {2'b00, ma_d};
  end

  // One restoring-division step
  logic [RW-1:0] mb_ext;
  logic          q_bit;
  logic [RW-1:0] r_step;

  always_comb begin
    mb_ext = {2'b00, mb_q};
    q_bit  = r_q >= mb_ext;
    r_step = (q_bit ? r_q - mb_ext : r_q) << 1;
  end

  // Rounding of the finished quotient
  logic [MANT-1:0] frac_rnd;
  logic [EXP-1:0]  e_rnd;

  fp_round_rne #(
    .EXP  (EXP),
    .MANT (MANT)
  ) u_round (
    .frac_i   (quo_q[MANT:1]),
    .guard_i  (quo_q[0]),
    .sticky_i (|r_q),
    .exp_i    (e_q),
    .frac_o   (frac_rnd),
    .exp_o    (e_rnd)
  );

  // Control FSM with registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      c_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            busy_q  <= 1'b1;
            state_q <= zero_in ? SPECIAL : NORM;
          end
        end
        SPECIAL: begin
          // A zero divisor wins over a zero dividend.
          c_q     <= zero_b ? {sign_c, {EXP{1'b1}}, {MANT{1'b0}}} : '0;
          dbz_q   <= zero_b;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        NORM: begin
          cnt_q   <= '0;
          state_q <= DIV;
        end
        DIV: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_IT) state_q <= ROUND;
        end
        ROUND: begin
          c_q     <= {sign_c, e_rnd, frac_rnd};
          dbz_q   <= 1'b0;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Datapath: operands, remainder, quotient and exponent (no reset needed)
  always_ff @(posedge clk_i) begin
    case (state_q)
      IDLE: begin
        if (start_i) begin
          a_q <= a_i;
          b_q <= b_i;
        end
      end
      NORM: begin
        mb_q <= mb_d;
        r_q  <= r_d;
        e_q  <= e_d;
      end
      DIV: begin
        r_q   <= r_step;
        quo_q <= {quo_q[MANT-1:0], q_bit};
      end
      default: ;
    endcase
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign c_o    = c_q;
  assign dbz_o  = dbz_q;

endmodule

// File: tb/tb_fdiv_seq.sv
// -----------------------------------------------------------------------------
// tb_fdiv_seq
//   Self-checking bench for fdiv_seq at the binary32 defaults: fixed vectors,
//   handshake and asynchronous-reset sequences, and random operands compared
//   against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_fdiv_seq;

  logic        clk;
  logic        rst_ni;
  logic        start_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] c_o;
  logic        dbz_o;

  int checks = 0;
  int errors = 0;

  fdiv_seq dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .start_i (start_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .c_o     (c_o),
    .dbz_o   (dbz_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: quotient of the significands scaled to MANT+2 bits, then RNE.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] c, output logic dbz,
                                output int lat);
    longint ma, mb, num, q, rem, frac, e;
    logic s;
    int adj;
    s = a[31] ^ b[31];
    if (b[30:23] == 8'd0) begin
      c = {s, 8'hFF, 23'd0}; dbz = 1'b1; lat = 1;
    end else if (a[30:23] == 8'd0) begin
      c = 32'd0; dbz = 1'b0; lat = 1;
    end else begin
      ma   = longint'({1'b1, a[22:0]});
      mb   = longint'({1'b1, b[22:0]});
      adj  = (ma < mb) ? 1 : 0;
      num  = ma << (24 + adj);
      q    = num / mb;
      rem  = num % mb;
      frac = (q >> 1) & 64'h7FFFFF;
      e    = (longint'(a[30:23]) - longint'(b[30:23]) + 127 - adj) & 255;
      if ((q & 1) != 0 && (rem != 0 || (frac & 1) != 0)) frac = frac + 1;
      if (frac == 64'h800000) begin
        frac = 0;
        e    = (e + 1) & 255;
      end
      c   = {s, e[7:0], frac[22:0]};
      dbz = 1'b0;
      lat = 27;
    end
  endfunction

  // Issue one op and wait (bounded) for done_o; lat counts edges after capture.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] c, output logic dbz, output int lat);
    @(negedge clk);
    a_i = a; b_i = b; start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_o) begin
        lat = k;
        break;
      end
    end
    c = c_o; dbz = dbz_o;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t        tbl[10];
  logic [31:0] rc, mc;
  logic        rdbz, mdbz;
  int          rlat, mlat;
  logic [31:0] ra, rb;
  logic        held_ok;

  initial begin
    tbl[0] = '{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 27};
    tbl[1] = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 27};
    tbl[2] = '{32'h3F800000, 32'h3FC00000, 32'h3F2AAAAB, 1'b0, 27};
    tbl[3] = '{32'hC0F00000, 32'h40200000, 32'hC0400000, 1'b0, 27};
    tbl[4] = '{32'h00000000, 32'h3F800000, 32'h00000000, 1'b0, 1};
    tbl[5] = '{32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1, 1};
    tbl[6] = '{32'h00000000, 32'h00000000, 32'h7F800000, 1'b1, 1};
    tbl[7] = '{32'h007FFFFF, 32'h3F800000, 32'h00000000, 1'b0, 1};
    tbl[8] = '{32'h40000000, 32'h80123456, 32'hFF800000, 1'b1, 1};
    tbl[9] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 27};

    rst_ni = 1'b0; start_i = 1'b0; a_i = '0; b_i = '0;
    repeat (2) @(negedge clk);
    chk("reset c_o", c_o, 32'd0);
    chk("reset busy_o", 32'(busy_o), 32'd0);
    chk("reset done_o", 32'(done_o), 32'd0);
    chk("reset dbz_o", 32'(dbz_o), 32'd0);
    rst_ni = 1'b1;

    // Fixed vectors
    for (int i = 0; i < 10; i++) begin
      do_op(tbl[i].a, tbl[i].b, rc, rdbz, rlat);
      chk($sformatf("vec%0d c_o", i), rc, tbl[i].c);
      chk($sformatf("vec%0d dbz_o", i), 32'(rdbz), 32'(tbl[i].dbz));
      chk($sformatf("vec%0d latency", i), 32'(rlat), 32'(tbl[i].lat));
      chk($sformatf("vec%0d busy_o at done", i), 32'(busy_o), 32'd0);
    end

    // start_i held with changing operands; a new start in the done cycle
    @(negedge clk);
    a_i = 32'h40C00000; b_i = 32'h40000000; start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_i = $urandom; b_i = $urandom;
    rlat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_o) begin
        rlat = k;
        break;
      end
      a_i = $urandom; b_i = $urandom;
    end
    chk("held start c_o", c_o, 32'h40400000);
    chk("held start latency", 32'(rlat), 32'd27);
    chk("held start busy_o at done", 32'(busy_o), 32'd0);
    a_i = 32'h3F800000; b_i = 32'h40400000;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    chk("done pulse width", 32'(done_o), 32'd0);
    chk("restart busy_o", 32'(busy_o), 32'd1);
    held_ok = 1'b1;
    rlat = -1;
    for (int k = 1; k <= 100; k++) begin
      if (c_o !== 32'h40400000) held_ok = 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (done_o) begin
        rlat = k;
        break;
      end
    end
    chk("old result held", 32'(held_ok), 32'd1);
    chk("restart c_o", c_o, 32'h3EAAAAAB);
    chk("restart latency", 32'(rlat), 32'd27);

    // Asynchronous reset in the middle of an operation
    @(negedge clk);
    a_i = 32'h40C00000; b_i = 32'h40000000; start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("busy_o before reset", 32'(busy_o), 32'd1);
    #1 rst_ni = 1'b0;
    #1;
    chk("async reset c_o", c_o, 32'd0);
    chk("async reset busy_o", 32'(busy_o), 32'd0);
    chk("async reset done_o", 32'(done_o), 32'd0);
    chk("async reset dbz_o", 32'(dbz_o), 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    do_op(32'h3F800000, 32'h40400000, rc, rdbz, rlat);
    chk("after reset c_o", rc, 32'h3EAAAAAB);
    chk("after reset latency", 32'(rlat), 32'd27);

    // Random operands against the reference model
    for (int i = 0; i < 30; i++) begin
      ra = $urandom; rb = $urandom;
      ra[30:23] = 8'($urandom_range(1, 254));
      rb[30:23] = 8'($urandom_range(1, 254));
      if ($urandom_range(0, 9) == 0) ra[30:23] = 8'd0;
      if ($urandom_range(0, 9) == 0) rb[30:23] = 8'd0;
      model(ra, rb, mc, mdbz, mlat);
      do_op(ra, rb, rc, rdbz, rlat);
      chk($sformatf("rand%0d %h/%h c_o", i, ra, rb), rc, mc);
      chk($sformatf("rand%0d dbz_o", i), 32'(rdbz), 32'(mdbz));
      chk($sformatf("rand%0d latency", i), 32'(rlat), 32'(mlat));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
